// File: rtl/alu_share_arbiter.sv
// Round-robin arbiter sharing one ALU between two requesters.
// Latches the winner's op/operands for LAT cycles, then returns the captured result with a done pulse.
module alu_share_arbiter #(
  parameter int unsigned W   = 32,
  parameter int unsigned LAT = 2
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         req0,
  input  logic [2:0]   aluop0,
  input  logic [5:0]   funct0,
  input  logic [W-1:0] a0,
  input  logic [W-1:0] b0,
  input  logic         req1,
  input  logic [2:0]   aluop1,
  input  logic [5:0]   funct1,
  input  logic [W-1:0] a1,
  input  logic [W-1:0] b1,
  output logic [2:0]   alu_aluop,
  output logic [5:0]   alu_funct,
  output logic [W-1:0] alu_a,
  output logic [W-1:0] alu_b,
  input  logic [W-1:0] alu_result,
  output logic [W-1:0] res,
  output logic         done0,
  output logic         done1,
  output logic         busy
);

  localparam int unsigned CW = (LAT < 2) ? 1 : $clog2(LAT + 1);

  typedef enum logic [1:0] {StIdle, StExec, StDone} state_e;

  state_e        state;
  logic [CW-1:0] cnt;
  logic          owner;
  logic          ptr;
  logic          win;

  // On a tie the requester that did not win last time gets the grant.
  assign win  = (req0 && req1) ? ~ptr : req1;
  assign busy = (state != StIdle);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= StIdle;
      cnt       <= '0;
      owner     <= 1'b0;
      ptr       <= 1'b1;
      res       <= '0;
      done0     <= 1'b0;
      done1     <= 1'b0;
      alu_aluop <= '0;
      alu_funct <= '0;
      alu_a     <= '0;
      alu_b     <= '0;
    end else begin
      case (state)
        StIdle: begin
          if (req0 || req1) begin
            alu_aluop <= win ? aluop1 : aluop0;
            alu_funct <= win ? funct1 : funct0;
            alu_a     <= win ? a1 : a0;
            alu_b     <= win ? b1 : b0;
            owner     <= win;
            ptr       <= win;
            cnt       <= CW'(LAT);
            state     <= StExec;
          end
        end
        StExec: begin
          if (cnt > CW'(1)) begin
            cnt <= cnt - CW'(1);
          end else begin
            res   <= alu_result;
            done0 <= ~owner;
            done1 <= owner;
            state <= StDone;
          end
        end
        StDone: begin
          done0 <= 1'b0;
          done1 <= 1'b0;
          state <= StIdle;
        end
        default: state <= StIdle;
      endcase
    end
  end

endmodule
